stream_color_filter: RTL and testbench
======================================

Name: stream_color_filter

Overview:
- Streaming, parametrised successor to the whole-frame combinational green filter.
- Accepts one pixel per beat over a valid/ready stream and emits one registered mask bit per pixel.
- Mask is 0 when every channel lies inside a configurable inclusive [lower, upper] window, else 1.
- Tracks frame position, frames the output with row/frame markers, and sits between the pixel source and the downstream binary-mask consumer.

Parameters:
- CH, 3, colour channels per pixel.
- BW, 8, bits per channel (unsigned).
- IMG_W, 300, pixels per row (>=2).
- IMG_H, 200, rows per frame (>=2).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_lower  input  CH*BW  per-channel lower bound; channel c occupies [c*BW +: BW].
- cfg_upper  input  CH*BW  per-channel upper bound, same packing.
- in_valid  input  1  pixel beat valid.
- in_ready  output  1  block can accept a beat.
- in_pixel  input  CH*BW  pixel, same packing.
- out_valid  output  1  mask beat valid.
- out_ready  input  1  consumer accepts the mask beat.
- out_mask  output  1  0 = all channels in window, 1 = otherwise.
- out_eol  output  1  beat is the last pixel of a row.
- out_eof  output  1  beat is the last pixel of the frame.
- frame_done  output  1  one-cycle pulse (FILTER_STATS_EN only).
- match_count  output  $clog2(IMG_W*IMG_H+1)  in-window pixels of the last frame (FILTER_STATS_EN only).

Behaviour:
- Reset (async assert, sync deassert internally): out_valid=0, out_mask=0, out_eol=0, out_eof=0, col=0, row=0, state=IDLE, latched bounds=0, frame_done=0, match_count=0, running count=0.
- Handshake: a beat transfers when valid && ready.
  - in_ready = !out_valid || out_ready, combinational.
  - Single output register gives 1-cycle latency and full throughput.
  - Output fields hold stable while out_valid && !out_ready.
  - A simultaneous output drain and input accept in the same cycle loads the new beat; no bubble.
- State machine:
  - IDLE: on the first accepted beat, latch cfg_lower/cfg_upper into shadow registers and move to ACTIVE. That pixel is compared against the newly latched (current cfg) values.
  - ACTIVE: all pixels use the shadow bounds; cfg changes mid-frame have no effect until the next frame.
  - When the accepted beat is the frame's last pixel (row=IMG_H-1, col=IMG_W-1), return to IDLE.
- Comparison: unsigned and inclusive on both ends. A channel with lower>upper never matches, so its pixels give mask=1.
- Counters:
  - col increments per accepted beat and wraps IMG_W-1 -> 0; on that wrap, row increments.
  - row wraps IMG_H-1 -> 0.
  - out_eol=1 when col=IMG_W-1. out_eof=1 when the beat is the frame's last pixel; out_eol is also 1 on that beat.
- Reset mid-frame: the partial frame is discarded and the next accepted beat is treated as pixel (0,0).
- No input backpressure is generated beyond the in_ready rule; the block never drops or duplicates beats.

Optional Feature:
- Macro FILTER_STATS_EN.
- Defined:
  - A running counter increments for each accepted beat whose mask=0, and resets to 0 at frame start.
  - When the eof beat is accepted, match_count <= final count (including that beat) and frame_done pulses for 1 cycle, coincident with out_valid of the eof beat.
  - match_count holds until the next frame ends.
- Undefined: frame_done and match_count are tied to 0 and the counter logic is absent.

Decomposition:
- Package color_filter_pkg holds:
  - default CH, BW, IMG_W, IMG_H constants;
  - a function returning the count width, $clog2(w*h+1);
  - typedef pixel_t as a packed [CH-1:0][BW-1:0] array for benches.
- Sub-module pixel_window_cmp: combinational, one pixel against lower/upper for all channels, outputs in_window. Instantiated once in the datapath.

Test Plan (IMG_W=4, IMG_H=2, CH=3, BW=8 unless noted):
- Bounds lower=(0,100,0), upper=(80,255,80); stream (10,150,20), (90,150,20), (80,100,80), (0,99,0) continuously -> masks 0,1,0,1 at 1-cycle latency; beat 4 has out_eol=1.
- A full 8-pixel frame with out_ready held 0 for cycles 3-6 -> in_ready=0 during the stall, output beat unchanged, no loss; 8 beats out; only beat 8 has out_eof=1.
- cfg_upper G changed from 255 to 120 after pixel 2 of frame 1 -> pixel (0,150,0) still gives mask 0 in frame 1 and mask 1 in frame 2.
- Channel R set with lower=200, upper=100 -> every pixel gives mask 1.
- FILTER_STATS_EN, a frame with 5 in-window pixels -> frame_done pulses once with the eof beat and match_count=5; the next frame with 0 matches gives match_count=0.
- rst asserted after 3 accepted beats, then released, and 8 pixels sent -> out_eol on beats 4 and 8, out_eof only on beat 8, and match_count reflects only the post-reset frame.

Source files
------------

// File: rtl/color_filter_pkg.sv
// Shared defaults, count-width helper and pixel/state types for the stream colour filter.
package color_filter_pkg;

    localparam int unsigned CH_DEF    = 3;
    localparam int unsigned BW_DEF    = 8;
    localparam int unsigned IMG_W_DEF = 300;
    localparam int unsigned IMG_H_DEF = 200;

    // Bits needed to hold a per-frame pixel count from 0 to w*h inclusive.
    function automatic int unsigned count_width(input int unsigned w, input int unsigned h);
        return $clog2(w * h + 1);
    endfunction

    typedef logic [CH_DEF-1:0][BW_DEF-1:0] pixel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/stream_color_filter_cmp.sv
// pixel_window_cmp: combinational check that every channel of a pixel lies in [lower, upper].
module pixel_window_cmp
    import color_filter_pkg::*;
#(
    parameter int unsigned CH = CH_DEF,
    parameter int unsigned BW = BW_DEF
) (
    input  logic [CH*BW-1:0] pixel_i,
    input  logic [CH*BW-1:0] lower_i,
    input  logic [CH*BW-1:0] upper_i,
    output logic             in_window_o
);

    // An inverted window (lower > upper) can never satisfy both bounds.
    always_comb begin
        in_window_o = 1'b1;
        for (int unsigned c = 0; c < CH; c++) begin
            if ((pixel_i[c*BW +: BW] < lower_i[c*BW +: BW]) ||
                (pixel_i[c*BW +: BW] > upper_i[c*BW +: BW])) begin
                in_window_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_color_filter.sv
// Streaming colour-window filter: one registered mask bit per pixel with row/frame markers.
// Define FILTER_STATS_EN to add the per-frame in-window count and frame_done pulse.
module stream_color_filter
    import color_filter_pkg::*;
#(
    parameter int unsigned CH    = CH_DEF,
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CH*BW-1:0]                      cfg_lower,
    input  logic [CH*BW-1:0]                      cfg_upper,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [CH*BW-1:0]                      in_pixel,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_mask,
    output logic                                  out_eol,
    output logic                                  out_eof,
    output logic                                  frame_done,
    output logic [count_width(IMG_W, IMG_H)-1:0]  match_count
);

    localparam int unsigned PW    = CH * BW;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PW-1:0]      lower_q, lower_d;
    logic [PW-1:0]      upper_q, upper_d;
    logic               out_valid_q, out_valid_d;
    logic               out_mask_q, out_mask_d;
    logic               out_eol_q, out_eol_d;
    logic               out_eof_q, out_eof_d;
    logic [1:0]         rst_sync_q;
    logic               rst_int;
    logic               accept_c;
    logic               last_col_c;
    logic               last_pix_c;
    logic               in_window_c;
    logic [PW-1:0]      act_lower_c;
    logic [PW-1:0]      act_upper_c;

    // Reset asserts immediately and releases two clocks after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end
    assign rst_int = rst_sync_q[1];

    assign in_ready    = (!out_valid_q || out_ready) && !rst_int;
    assign accept_c    = in_valid && in_ready;
    assign last_col_c  = (col_q == COL_W'(IMG_W - 1));
    assign last_pix_c  = last_col_c && (row_q == ROW_W'(IMG_H - 1));
    // The first pixel of a frame sees live cfg, the rest see the latched copy.
    assign act_lower_c = (state_q == IDLE) ? cfg_lower : lower_q;
    assign act_upper_c = (state_q == IDLE) ? cfg_upper : upper_q;

    pixel_window_cmp #(
        .CH (CH),
        .BW (BW)
    ) u_cmp (
        .pixel_i     (in_pixel),
        .lower_i     (act_lower_c),
        .upper_i     (act_upper_c),
        .in_window_o (in_window_c)
    );

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            lower_q     <= '0;
            upper_q     <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        lower_d     = lower_q;
        upper_d     = upper_q;
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_mask_d  = !in_window_c;
            out_eol_d   = last_col_c;
            out_eof_d   = last_pix_c;
            if (state_q == IDLE) begin
                lower_d = cfg_lower;
                upper_d = cfg_upper;
            end
            state_d = last_pix_c ? IDLE : ACTIVE;
            if (last_col_c) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;

`ifdef FILTER_STATS_EN
    localparam int unsigned CNT_W = count_width(IMG_W, IMG_H);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] cnt_sum_c;

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            run_cnt_q    <= '0;
            match_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            match_cnt_q  <= match_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Count restarts on the first beat of a frame and publishes on the eof beat.
    always_comb begin
        run_cnt_d    = run_cnt_q;
        match_cnt_d  = match_cnt_q;
        frame_done_d = 1'b0;
        cnt_sum_c    = ((state_q == IDLE) ? CNT_W'(0) : run_cnt_q) + CNT_W'(in_window_c);
        if (accept_c) begin
            run_cnt_d = last_pix_c ? CNT_W'(0) : cnt_sum_c;
            if (last_pix_c) begin
                match_cnt_d  = cnt_sum_c;
                frame_done_d = 1'b1;
            end
        end
    end

    assign frame_done  = frame_done_q;
    assign match_count = match_cnt_q;
`else
    assign frame_done  = 1'b0;
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_stream_color_filter.sv
// Bench for stream_color_filter: directed + random streams checked against a frame-position model.
module tb_stream_color_filter;
    import color_filter_pkg::*;

    localparam int CH    = 3;
    localparam int BW    = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int PW    = CH * BW;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CW    = int'(count_width(IMG_W, IMG_H));

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] cfg_lower, cfg_upper, in_pixel;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic          out_mask, out_eol, out_eof, frame_done;
    logic [CW-1:0] match_count;

    stream_color_filter #(.CH(CH), .BW(BW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst(rst), .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [2:0]    exp_q[$];     // {mask, eol, eof} per accepted beat, in order
    int            pos = 0;      // index of next pixel within the frame
    int            cnt = 0;
    logic [CW-1:0] model_mc = '0;
    bit            exp_fd = 1'b0;
    logic [PW-1:0] flo = '0, fhi = '0;
    bit            hold_pend = 1'b0;
    logic [3:0]    prev_out = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkpx(input int r, input int g, input int b);
        pixel_t p;
        p[0] = BW'(r);
        p[1] = BW'(g);
        p[2] = BW'(b);
        return p;
    endfunction

    function automatic bit in_win(input logic [PW-1:0] px, input logic [PW-1:0] lo,
                                  input logic [PW-1:0] hi);
        int v, l, h;
        for (int c = 0; c < CH; c++) begin
            v = int'(px[c*BW +: BW]);
            l = int'(lo[c*BW +: BW]);
            h = int'(hi[c*BW +: BW]);
            if (v < l || v > h) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [PW-1:0] rand_px();
        logic [PW-1:0] p;
        int l, h;
        for (int c = 0; c < CH; c++) begin
            l = int'(cfg_lower[c*BW +: BW]);
            h = int'(cfg_upper[c*BW +: BW]);
            if (l <= h && ($urandom % 4) != 0)
                p[c*BW +: BW] = BW'($urandom_range(h, l));
            else
                p[c*BW +: BW] = BW'($urandom_range(255, 0));
        end
        return p;
    endfunction

    task automatic model_accept(input logic [PW-1:0] px);
        bit m;
        if (pos == 0) begin
            flo = cfg_lower;
            fhi = cfg_upper;
            cnt = 0;
        end
        m = !in_win(px, flo, fhi);
        exp_q.push_back({m, (pos % IMG_W) == IMG_W - 1, pos == NPIX - 1});
        if (!m) cnt++;
        if (pos == NPIX - 1) begin
            model_mc = CW'(cnt);
            exp_fd   = 1'b1;
        end
        pos = (pos + 1) % NPIX;
    endtask

    // One clock: check registered outputs, drive inputs, predict, then step past the edge.
    task automatic cycle(input bit iv, input logic [PW-1:0] px, input bit ordy, output bit acc);
        bit exp_ov, exp_rdy;
        logic [2:0] f;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (hold_pend) chk("hold", 32'({out_valid, out_mask, out_eol, out_eof}), 32'(prev_out));
`ifdef FILTER_STATS_EN
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("match_count", 32'(match_count), 32'(model_mc));
`else
        chk("frame_done", 32'(frame_done), 32'(0));
        chk("match_count", 32'(match_count), 32'(0));
`endif
        in_valid  = iv;
        in_pixel  = px;
        out_ready = ordy;
        #1;
        exp_ov  = (exp_q.size() != 0);
        exp_rdy = !exp_ov || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_ov) begin
            f = exp_q[0];
            chk("out_mask", 32'(out_mask), 32'(f[2]));
            chk("out_eol", 32'(out_eol), 32'(f[1]));
            chk("out_eof", 32'(out_eof), 32'(f[0]));
            if (ordy) void'(exp_q.pop_front());
        end
        acc    = iv && exp_rdy;
        exp_fd = 1'b0;
        if (acc) model_accept(px);
        hold_pend = exp_ov && !ordy;
        prev_out  = {out_valid, out_mask, out_eol, out_eof};
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] px);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, px, 1'b1, acc);
            n++;
        end
        n_cmp++;
        assert (acc) else begin
            n_err++;
            $error("FAIL accept_timeout: got 0 expected 1");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_mask", 32'(out_mask), 32'(0));
        chk("rst_out_eol", 32'(out_eol), 32'(0));
        chk("rst_out_eof", 32'(out_eof), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_match_count", 32'(match_count), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        pos = 0; cnt = 0; model_mc = '0; exp_fd = 1'b0; hold_pend = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent, cyc;
        logic [PW-1:0] px;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
        cfg_lower = '0; cfg_upper = '0;
        do_reset();

        // Basic window with a full row of mixed pixels
        cfg_lower = mkpx(0, 100, 0);
        cfg_upper = mkpx(80, 255, 80);
        send(mkpx(10, 150, 20));
        send(mkpx(90, 150, 20));
        send(mkpx(80, 100, 80));
        send(mkpx(0, 99, 0));
        for (int i = 0; i < 4; i++) send(rand_px());
        idle(2);

        // Downstream stall in the middle of a frame
        sent = 0; cyc = 0; px = rand_px();
        while ((sent < NPIX || exp_q.size() != 0) && cyc < 40) begin
            cyc++;
            cycle(sent < NPIX, px, !(cyc >= 3 && cyc <= 6), acc);
            if (acc) begin sent++; px = rand_px(); end
        end
        chk("stall_beats_sent", 32'(sent), 32'(NPIX));

        // Mid-frame cfg change only applies from the next frame
        send(mkpx(0, 150, 0));
        send(mkpx(0, 150, 0));
        cfg_upper = mkpx(80, 120, 80);
        send(mkpx(0, 150, 0));
        for (int i = 0; i < 5; i++) send(rand_px());
        send(mkpx(0, 150, 0));
        for (int i = 0; i < 7; i++) send(rand_px());
        idle(1);

        // Inverted red window never matches
        cfg_lower = mkpx(200, 0, 0);
        cfg_upper = mkpx(100, 255, 255);
        for (int i = 0; i < NPIX; i++) send(rand_px());
        idle(1);

        // Frame with 5 matches, then a frame with none
        cfg_lower = mkpx(0, 100, 0);
        cfg_upper = mkpx(80, 255, 80);
        for (int i = 0; i < NPIX; i++)
            send((i % 3 == 1) ? mkpx(90, 150, 20) : mkpx(10, 150, 20));
        idle(2);
        for (int i = 0; i < NPIX; i++) send(mkpx(90 + i, 150, 20));
        idle(3);

        // Reset in the middle of a frame discards the partial frame
        for (int i = 0; i < 3; i++) send(mkpx(10, 150, 20));
        do_reset();
        for (int i = 0; i < NPIX; i++)
            send((i < 6) ? mkpx(5, 200, 5) : mkpx(5, 50, 5));
        idle(3);

        // Random traffic with random bounds and random backpressure
        px = rand_px();
        for (int i = 0; i < 800; i++) begin
            if (i % 13 == 0) begin
                for (int c = 0; c < CH; c++) begin
                    cfg_lower[c*BW +: BW] = BW'($urandom_range(120, 0));
                    cfg_upper[c*BW +: BW] = BW'($urandom_range(255, 90));
                end
            end
            cycle(($urandom % 4) != 0, px, ($urandom % 4) != 0, acc);
            if (acc) px = rand_px();
        end
        idle(4);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
